conv_job_sequencer: RTL and testbench

//  Host-side scheduler for the convolution core. Takes one job descriptor (sizes of X and Y).

---
 rtl/conv_job_sequencer_pkg.sv | 17 +
 rtl/conv_job_sequencer_addr_cnt.sv | 18 +
 rtl/conv_job_sequencer.sv | 126 ++++++++++++
 tb/tb_conv_job_sequencer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_job_sequencer_pkg.sv
// conv_job_sequencer_pkg: shared state encoding and default widths for the convolution job sequencer
package conv_pkg;
  localparam int DATA_W      = 8;
  localparam int Z_W         = 16;
  localparam int ADDR_W      = 5;
  localparam int TIMEOUT_CYC = 4096;
  typedef enum logic [2:0] {
    IDLE,
    LOAD_X,
    LOAD_Y,
    START,
    RUN,
    RD_ADDR,
    RD_WAIT,
    OUT
  } seq_state_t;
endpackage

// File: rtl/conv_job_sequencer_addr_cnt.sv
// conv_addr_cnt: clearable up-counter flagging the final count before limit
module conv_addr_cnt #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic [W-1:0] cnt,
  output logic         hit
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= cnt + 1'b1;
  assign hit = cnt == limit - 1'b1;
endmodule

// File: rtl/conv_job_sequencer.sv
// conv_job_sequencer: loads X/Y into the convolution core, starts it, and streams Z back out
module conv_job_sequencer #(
  parameter int DATA_W      = conv_pkg::DATA_W,
  parameter int Z_W         = conv_pkg::Z_W,
  parameter int ADDR_W      = conv_pkg::ADDR_W,
  parameter int TIMEOUT_CYC = conv_pkg::TIMEOUT_CYC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [ADDR_W-1:0] cfg_size_x,
  input  logic [ADDR_W-1:0] cfg_size_y,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              mem_we,
  output logic              mem_sel,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [ADDR_W-1:0] core_size_x,
  output logic [ADDR_W-1:0] core_size_y,
  output logic              core_start,
  input  logic              core_busy,
  input  logic              core_done,
  output logic [ADDR_W:0]   zmem_addr,
  input  logic [Z_W-1:0]    zmem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [Z_W-1:0]    out_data,
  output logic              out_last,
  output logic              busy,
  output logic              err
);
  import conv_pkg::*;
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  seq_state_t state, next_state;
  logic accept, bad_cfg, take_cfg, timeout, y_done;
  logic ld_hit, rd_hit, wd_hit;
  logic [ADDR_W-1:0] ld_cnt, ld_limit;
  logic [ADDR_W:0] rd_cnt, z_len;
  logic [WD_W-1:0] wd_cnt;

  assign accept   = in_valid && in_ready;
  assign bad_cfg  = cfg_size_x == '0 || cfg_size_y == '0;
  assign take_cfg = cfg_ready && cfg_valid && !bad_cfg;
  assign timeout  = (state == START || state == RUN) && wd_hit;
  assign ld_limit = state == LOAD_X ? core_size_x : core_size_y;
  assign z_len    = {1'b0, core_size_x} + {1'b0, core_size_y} - 1'b1;
  assign zmem_addr = rd_cnt;

  conv_addr_cnt #(.W(ADDR_W)) u_ld (
    .clk(clk), .rst_n(rst_n),
    .clr(!(state == LOAD_X || state == LOAD_Y) || (state == LOAD_X && accept && ld_hit)),
    .en(accept), .limit(ld_limit), .cnt(ld_cnt), .hit(ld_hit)
  );

  conv_addr_cnt #(.W(ADDR_W + 1)) u_rd (
    .clk(clk), .rst_n(rst_n),
    .clr(!(state inside {RD_ADDR, RD_WAIT, OUT})),
    .en(state == OUT && out_ready && !rd_hit), .limit(z_len), .cnt(rd_cnt), .hit(rd_hit)
  );

  // Held clear outside START/RUN so it reads zero on the first START cycle
  conv_addr_cnt #(.W(WD_W)) u_wd (
    .clk(clk), .rst_n(rst_n),
    .clr(!(state == START || state == RUN)),
    .en(1'b1), .limit(WD_W'(TIMEOUT_CYC)), .cnt(wd_cnt), .hit(wd_hit)
  );

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= next_state;

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    next_state = take_cfg ? LOAD_X : IDLE;
      LOAD_X:  next_state = accept && ld_hit ? LOAD_Y : LOAD_X;
      LOAD_Y:  next_state = y_done ? START : LOAD_Y;
      START:   next_state = timeout ? IDLE : core_busy ? RUN : START;
      RUN:     next_state = timeout ? IDLE : (!core_busy && core_done) ? RD_ADDR : RUN;
      RD_ADDR: next_state = RD_WAIT;
      RD_WAIT: next_state = OUT;
      OUT:     next_state = !out_ready ? OUT : rd_hit ? IDLE : RD_ADDR;
      default: next_state = IDLE;
    endcase
  end

  // After the last Y sample, y_done stalls in_ready for the cycle its write lands
  always_comb begin
    cfg_ready  = state == IDLE;
    in_ready   = state == LOAD_X || (state == LOAD_Y && !y_done);
    core_start = state == START;
    out_valid  = state == OUT;
    out_last   = out_valid && rd_hit;
    busy       = state != IDLE;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mem_we      <= 1'b0;
      mem_sel     <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      y_done      <= 1'b0;
      err         <= 1'b0;
      core_size_x <= '0;
      core_size_y <= '0;
      out_data    <= '0;
    end else begin
      mem_we <= accept;
      if (accept) begin
        mem_sel   <= state == LOAD_Y;
        mem_addr  <= ld_cnt;
        mem_wdata <= in_data;
      end
      y_done <= state == LOAD_Y && accept && ld_hit;
      err    <= (cfg_ready && cfg_valid && bad_cfg) || timeout;
      if (take_cfg) begin
        core_size_x <= cfg_size_x;
        core_size_y <= cfg_size_y;
      end
      if (state == RD_WAIT) out_data <= zmem_rdata;
    end
endmodule

// File: tb/tb_conv_job_sequencer.sv
// tb_conv_job_sequencer: table-driven jobs plus directed timeout, bad-descriptor and mid-load reset sequences
module tb_conv_job_sequencer;
  logic clk, rst_n;
  logic cfg_valid, cfg_ready;
  logic [4:0] cfg_size_x, cfg_size_y;
  logic in_valid, in_ready;
  logic [7:0] in_data;
  logic mem_we, mem_sel;
  logic [4:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [4:0] core_size_x, core_size_y;
  logic core_start;
  logic core_busy = 1'b0;
  logic core_done = 1'b1;
  logic [5:0] zmem_addr;
  logic [15:0] zmem_rdata;
  logic out_valid, out_ready, out_last, busy, err;
  logic [15:0] out_data;

  conv_job_sequencer #(.DATA_W(8), .Z_W(16), .ADDR_W(5), .TIMEOUT_CYC(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_size_x(cfg_size_x), .cfg_size_y(cfg_size_y),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .core_size_x(core_size_x), .core_size_y(core_size_y), .core_start(core_start),
    .core_busy(core_busy), .core_done(core_done),
    .zmem_addr(zmem_addr), .zmem_rdata(zmem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .err(err)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  int checks = 0, errors = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Write-side monitor: logs every memory write and handshake-level events
  int we_sel[$], we_addr[$], we_data[$];
  logic [7:0] xm[32], ym[32];
  int starts = 0, errs = 0, overlap = 0;
  logic start_q = 1'b0;
  always @(negedge clk) begin
    if (mem_we) begin
      we_sel.push_back(int'(mem_sel));
      we_addr.push_back(int'(mem_addr));
      we_data.push_back(int'(mem_wdata));
      if (!mem_sel) xm[mem_addr] = mem_wdata;
      else ym[mem_addr] = mem_wdata;
    end
    if (core_start && !start_q) starts++;
    start_q = core_start;
    if (err) errs++;
    if (core_start && mem_we) overlap++;
  end

  // Core model: busy after 2 cycles, runs 5 cycles, then writes the convolution into Z
  logic hang = 1'b0;
  logic [15:0] zmem[64];
  int cst = 0, dly = 0;
  always @(posedge clk) begin
    int s, b, zl;
    if (!rst_n) begin
      cst = 0;
      core_busy <= 1'b0;
      core_done <= 1'b1;
    end else if (cst == 0) begin
      if (core_start) begin cst = 1; dly = 2; end
    end else if (cst == 1) begin
      dly = dly - 1;
      if (dly == 0) begin
        core_busy <= 1'b1;
        core_done <= 1'b0;
        cst = 2;
        dly = 5;
      end
    end else if (!hang) begin
      dly = dly - 1;
      if (dly == 0) begin
        zl = int'(core_size_x) + int'(core_size_y) - 1;
        for (int i = 0; i < 64; i++) begin
          s = 0;
          for (int a = 0; a < int'(core_size_x); a++) begin
            b = i - a;
            if (b >= 0 && b < int'(core_size_y)) s += int'(xm[a]) * int'(ym[b]);
          end
          zmem[i] <= i < zl ? s[15:0] : 16'hdead;
        end
        core_busy <= 1'b0;
        core_done <= 1'b1;
        cst = 0;
      end
    end
  end
  always @(posedge clk) zmem_rdata <= zmem[zmem_addr];

  typedef struct {
    int sx, sy;
    int x[4];
    int y[4];
    int z[8];
    int bp;
  } job_t;
  job_t jobs[4];

  task automatic send_cfg(input int sx, input int sy);
    int g = 0;
    @(negedge clk);
    while (!cfg_ready && g < 500) begin @(negedge clk); g++; end
    if (!cfg_ready) chk("cfg_ready_wait", 0, 1);
    cfg_valid = 1; cfg_size_x = 5'(sx); cfg_size_y = 5'(sy);
    @(negedge clk);
    cfg_valid = 0;
  endtask

  task automatic send_sample(input int d);
    int g = 0;
    in_valid = 1; in_data = 8'(d);
    while (!in_ready && g < 100) begin @(negedge clk); g++; end
    if (!in_ready) chk("in_ready_wait", 0, 1);
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic read_out(input int j);
    int n, g;
    logic [15:0] d0;
    n = jobs[j].sx + jobs[j].sy - 1;
    out_ready = 1;
    for (int k = 0; k < n; k++) begin
      if (k == jobs[j].bp) out_ready = 0;
      g = 0;
      while (!out_valid && g < 300) begin @(negedge clk); g++; end
      if (!out_valid) begin chk($sformatf("j%0d_valid_wait%0d", j, k), 0, 1); return; end
      if (k == jobs[j].bp) begin
        d0 = out_data;
        for (int h = 0; h < 10; h++) begin
          @(negedge clk);
          chk($sformatf("j%0d_bp_valid%0d", j, h), out_valid, 1);
          chk($sformatf("j%0d_bp_data%0d", j, h), out_data, d0);
        end
        out_ready = 1;
      end
      chk($sformatf("j%0d_data%0d", j, k), out_data, jobs[j].z[k]);
      chk($sformatf("j%0d_last%0d", j, k), out_last, k == n - 1);
      @(negedge clk);
    end
    chk($sformatf("j%0d_idle_after", j), busy, 0);
  endtask

  task automatic run_job(input int j);
    int sx, sy;
    sx = jobs[j].sx; sy = jobs[j].sy;
    we_sel.delete(); we_addr.delete(); we_data.delete();
    starts = 0; errs = 0;
    send_cfg(sx, sy);
    chk($sformatf("j%0d_size_x", j), core_size_x, sx);
    chk($sformatf("j%0d_size_y", j), core_size_y, sy);
    for (int i = 0; i < sx + sy; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send_sample(i < sx ? jobs[j].x[i] : jobs[j].y[i - sx]);
    end
    read_out(j);
    chk($sformatf("j%0d_nwe", j), we_addr.size(), sx + sy);
    for (int i = 0; i < we_addr.size() && i < sx + sy; i++) begin
      chk($sformatf("j%0d_we_sel%0d", j, i), we_sel[i], i >= sx);
      chk($sformatf("j%0d_we_addr%0d", j, i), we_addr[i], i < sx ? i : i - sx);
      chk($sformatf("j%0d_we_data%0d", j, i), we_data[i], i < sx ? jobs[j].x[i] : jobs[j].y[i - sx]);
    end
    chk($sformatf("j%0d_starts", j), starts, 1);
    chk($sformatf("j%0d_errs", j), errs, 0);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_cfg_ready"}, cfg_ready, 1);
    chk({tag, "_others"}, {in_ready, mem_we, mem_sel, mem_addr, mem_wdata, core_size_x, core_size_y,
        core_start, zmem_addr, out_valid, out_data, out_last, busy, err}, 0);
  endtask

  initial begin
    int t0, g;
    jobs[0] = '{3, 2, '{1, 2, 3, 0}, '{1, 1, 0, 0}, '{1, 3, 5, 3, 0, 0, 0, 0}, 1};
    jobs[1] = '{1, 1, '{5, 0, 0, 0}, '{7, 0, 0, 0}, '{35, 0, 0, 0, 0, 0, 0, 0}, -1};
    jobs[2] = '{2, 2, '{1, 2, 0, 0}, '{3, 4, 0, 0}, '{3, 10, 8, 0, 0, 0, 0, 0}, -1};
    jobs[3] = '{1, 3, '{2, 0, 0, 0}, '{1, 2, 3, 0}, '{2, 4, 6, 0, 0, 0, 0, 0}, 2};
    rst_n = 0; cfg_valid = 0; cfg_size_x = 0; cfg_size_y = 0;
    in_valid = 0; in_data = 0; out_ready = 1;
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst_n = 1;
    @(negedge clk);
    check_reset("post_reset");

    we_addr.delete(); we_sel.delete(); we_data.delete();
    cfg_valid = 1; cfg_size_x = 0; cfg_size_y = 4;
    in_valid = 1; in_data = 8'h55;
    @(negedge clk);
    cfg_valid = 0;
    chk("bad_x_err", err, 1);
    chk("bad_x_cfg_ready", cfg_ready, 1);
    chk("bad_x_busy", busy, 0);
    @(negedge clk);
    chk("bad_x_err_pulse", err, 0);
    cfg_valid = 1; cfg_size_x = 4; cfg_size_y = 0;
    @(negedge clk);
    cfg_valid = 0; in_valid = 0;
    chk("bad_y_err", err, 1);
    @(negedge clk);
    chk("bad_y_err_pulse", err, 0);
    chk("bad_no_we", we_addr.size(), 0);

    for (int j = 0; j < 4; j++) run_job(j);

    hang = 1;
    send_cfg(1, 1);
    send_sample(9);
    send_sample(9);
    g = 0;
    while (!core_start && g < 100) begin @(negedge clk); g++; end
    chk("to_start_seen", core_start, 1);
    t0 = cyc;
    g = 0;
    while (!err && g < 200) begin @(negedge clk); g++; end
    chk("to_cycles", cyc - t0, 64);
    chk("to_idle", cfg_ready, 1);
    @(negedge clk);
    chk("to_err_pulse", err, 0);
    hang = 0;
    repeat (20) @(negedge clk);

    send_cfg(2, 3);
    send_sample(4);
    send_sample(5);
    send_sample(6);
    rst_n = 0;
    #1;
    check_reset("mid_load_reset");
    @(negedge clk);
    rst_n = 1;
    run_job(1);

    chk("no_start_write_overlap", overlap, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1);
  end
endmodule
